// File: rtl/ahb_bram_bridge.sv
// AHB-Lite slave bridge onto a byte-writable dual-port block RAM
// (write port A, read port B with a 1-cycle registered read).
// Optional feature macro: AHB_BRAM_FWD_EN
//   defined   : a read that hits the word being written in the same cycle
//               is served by forwarding the write data (no wait state)
//   undefined : the same read takes exactly one STALL wait state
module ahb_bram_bridge #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic [31:0]           bram_dina,
  output logic [3:0]            bram_wea,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  input  logic [31:0]           bram_doutb
);

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    RDATA,
    STALL,
    ERR1,
    ERR2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [ADDR_WIDTH-1:0]   wr_idx;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic [3:0]              mask;
  logic [3:0]              wr_mask;
  logic                    accept;
  logic                    take;
  logic                    legal;
  logic                    hazard;
  logic                    hreadyout_q;
  logic                    hresp_q;
  logic                    unused_bits;

  assign accept = HSEL & HREADY & HTRANS[1];
  // ERR1 and STALL hold the bus; an address phase is never taken there
  assign take   = accept & (state != ERR1) & (state != STALL);
  assign idx    = HADDR[ADDR_WIDTH+1:2];
  assign hazard = take & legal & ~HWRITE & (state == WDATA) & (idx == wr_idx);

  assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  // Alignment check and byte-lane mask of the address-phase transfer
  always_comb begin
    legal = 1'b0;
    mask  = '0;
    case (HSIZE)
      3'd0: begin
        legal = 1'b1;
        mask  = 4'b0001 << HADDR[1:0];
      end
      3'd1: begin
        legal = ~HADDR[0];
        mask  = 4'b0011 << {HADDR[1], 1'b0};
      end
      3'd2: begin
        legal = (HADDR[1:0] == 2'b00);
        mask  = '1;
      end
      default: begin
        legal = 1'b0;
        mask  = '0;
      end
    endcase
  end

  // Next-state selection for the data-phase FSM
  always_comb begin
    state_nxt = state;
    case (state)
      ERR1:  state_nxt = ERR2;
      STALL: state_nxt = RDATA;
      default: begin
        if (take) begin
          if (!legal)
            state_nxt = ERR1;
          else if (HWRITE)
            state_nxt = WDATA;
`ifdef AHB_BRAM_FWD_EN
          else
            state_nxt = RDATA;
`else
          else
            state_nxt = hazard ? STALL : RDATA;
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // State register, registered handshake outputs and latched transfer info
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      wr_idx      <= '0;
      wr_mask     <= '0;
      rd_idx      <= '0;
    end else begin
      state       <= state_nxt;
      hreadyout_q <= !((state_nxt == ERR1) || (state_nxt == STALL));
      hresp_q     <= (state_nxt == ERR1) || (state_nxt == ERR2);
      if (take && legal) begin
        if (HWRITE) begin
          wr_idx  <= idx;
          wr_mask <= mask;
        end else begin
          rd_idx  <= idx;
        end
      end
    end
  end

`ifdef AHB_BRAM_FWD_EN
  logic [31:0] fwd_data;
  logic [3:0]  fwd_mask;

  // Capture the colliding write so the next RDATA cycle can overlay it
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fwd_data <= '0;
      fwd_mask <= '0;
    end else begin
      fwd_mask <= hazard ? wr_mask : '0;
      if (hazard)
        fwd_data <= HWDATA;
    end
  end
`endif

  assign HREADYOUT  = hreadyout_q;
  assign HRESP      = hresp_q;
  assign bram_addra = wr_idx;
  assign bram_dina  = HWDATA;
  assign bram_wea   = (state == WDATA) ? wr_mask : '0;
  // Read address goes straight to the RAM on a read accept for zero-wait reads
  assign bram_addrb = (take && legal && !HWRITE) ? idx : rd_idx;

  // Read data is only driven in the read data phase
  always_comb begin
    HRDATA = '0;
    if (state == RDATA) begin
`ifdef AHB_BRAM_FWD_EN
      for (int unsigned i = 0; i < 4; i++)
        HRDATA[8*i +: 8] = fwd_mask[i] ? fwd_data[8*i +: 8] : bram_doutb[8*i +: 8];
`else
      HRDATA = bram_doutb;
`endif
    end
  end

endmodule
